// File: rtl/ets_sweep_controller_pkg.sv
// Shared definitions for the equivalent-time sampling sweep controller and
// the sampler-side blocks that talk to it.
//   - sweep_state_t : FSM state encoding
//   - DEF_*         : default parameter values
//   - *_W           : datapath widths
package ets_sweep_controller_pkg;

  localparam int DEF_FIFO_DEPTH   = 16;
  localparam int DEF_STEP_TIMEOUT = 1024;

  localparam int STEP_W   = 16;  // phase-step counter / num_steps width
  localparam int RESULT_W = 32;  // sampler one-count width
  localparam int COUNT_W  = 7;   // external FIFO occupancy width (up to 64)

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_COLLECT   = 3'd2,
    S_STORE     = 3'd3,
    S_STEP      = 3'd4,
    S_STEP_WAIT = 3'd5,
    S_FINISH    = 3'd6
  } sweep_state_t;

endpackage

// File: rtl/ets_sweep_controller_if.sv
// Bundle of sweep control, PLL handshake, sampler handshake and result FIFO
// read signals.
//   master : the sweep controller (drives busy/done/timeout, phase_step,
//            request_run and the FIFO read-side outputs)
//   slave  : the environment (host, PLL and sampler)
interface ets_sweep_controller_if;
  import ets_sweep_controller_pkg::*;

  logic                start;
  logic [STEP_W-1:0]   num_steps;
  logic                busy;
  logic                done;
  logic                timeout;
  logic                phase_step;
  logic                phase_step_done;
  logic                request_run;
  logic                sampler_running;
  logic                result_ready;
  logic [RESULT_W-1:0] result;
  logic                rd_en;
  logic [RESULT_W-1:0] rd_data;
  logic                fifo_empty;
  logic [COUNT_W-1:0]  fifo_count;

  modport master (
    input  start, num_steps, phase_step_done, sampler_running,
           result_ready, result, rd_en,
    output busy, done, timeout, phase_step, request_run,
           rd_data, fifo_empty, fifo_count
  );

  modport slave (
    output start, num_steps, phase_step_done, sampler_running,
           result_ready, result, rd_en,
    input  busy, done, timeout, phase_step, request_run,
           rd_data, fifo_empty, fifo_count
  );

endinterface

// File: rtl/ets_sweep_controller_result_fifo.sv
// result_fifo: synchronous show-ahead FIFO holding sampler results.
//   clk, reset     : clock, asynchronous active-high reset
//   push/push_data : write one entry (caller must respect full)
//   pop            : advance head; ignored while empty
//   rd_data        : head entry, 0 while empty
//   full/empty     : status flags
//   count          : occupancy, 0..DEPTH
module result_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are valid, so clearing the array would only cost muxes.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;  // idle, or push+pop cancel out
      endcase
    end
  end

endmodule

// File: rtl/ets_sweep_controller.sv
// ets_sweep_controller: steps a PLL phase across num_steps positions, asks
// the sampler for a run at each position and queues the one-counts.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : start/num_steps in, busy/done/timeout out; phase_step /
//                phase_step_done to the PLL; request_run / sampler_running /
//                result_ready / result to the sampler; rd_en / rd_data /
//                fifo_empty / fifo_count for draining results
module ets_sweep_controller
  import ets_sweep_controller_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int STEP_TIMEOUT = DEF_STEP_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  ets_sweep_controller_if.master bus
);

  localparam int                TIMER_W    = $clog2(STEP_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_TIMEOUT - 1);
  localparam int                FCNT_W     = $clog2(FIFO_DEPTH) + 1;

  sweep_state_t        state_q, state_d;
  logic [STEP_W-1:0]   step_cnt_q;
  logic [STEP_W-1:0]   steps_q;     // num_steps captured at start
  logic [RESULT_W-1:0] result_q;
  logic [TIMER_W-1:0]  timer_q;
  logic                timeout_q;
  logic                fifo_full;
  logic                fifo_push;
  logic                last_store;
  logic                step_timed_out;
  logic [FCNT_W-1:0]   fifo_cnt;

  // The counter never exceeds steps_q-1, so +1 cannot wrap inside a sweep.
  assign last_store     = ((step_cnt_q + 16'd1) == steps_q);
  assign step_timed_out = (timer_q == TIMER_LAST);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: defaults come first so every path assigns every output of this
  // block and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    fifo_push = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = (bus.num_steps != '0) ? S_RUN : S_FINISH;
      end
      S_RUN:     if (bus.sampler_running) state_d = S_COLLECT;
      S_COLLECT: if (bus.result_ready)    state_d = S_STORE;
      S_STORE: begin
        // A full FIFO holds the sweep here; the latched result stays put.
        if (!fifo_full) begin
          fifo_push = 1'b1;
          state_d   = last_store ? S_FINISH : S_STEP;
        end
      end
      S_STEP: state_d = S_STEP_WAIT;
      S_STEP_WAIT: begin
        if (bus.phase_step_done)  state_d = S_RUN;
        else if (step_timed_out)  state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt_q <= '0;
      steps_q    <= '0;
      result_q   <= '0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && bus.num_steps != '0) begin
            step_cnt_q <= '0;
            steps_q    <= bus.num_steps;
            timeout_q  <= 1'b0;
          end
        end
        S_COLLECT:   if (bus.result_ready) result_q <= bus.result;
        S_STORE:     if (!fifo_full) step_cnt_q <= step_cnt_q + 1'b1;
        S_STEP:      timer_q <= '0;
        S_STEP_WAIT: begin
          timer_q <= timer_q + 1'b1;
          if (!bus.phase_step_done && step_timed_out) timeout_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_FINISH);
  assign bus.phase_step  = (state_q == S_STEP);
  assign bus.request_run = (state_q == S_RUN);
  assign bus.timeout     = timeout_q;
  assign bus.fifo_count  = COUNT_W'(fifo_cnt);

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RESULT_W)
  ) u_result_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (result_q),
    .pop       (bus.rd_en),
    .rd_data   (bus.rd_data),
    .full      (fifo_full),
    .empty     (bus.fifo_empty),
    .count     (fifo_cnt)
  );

endmodule
